// File: rtl/fft_disp_pkg.sv
// ---------------------------------------------------------------------------
// fft_disp_pkg
// Shared definitions for the display-side FFT spectrum reader: the reader
// FSM state encoding and the default bin count / bar height geometry.
// ---------------------------------------------------------------------------
package fft_disp_pkg;

  localparam int NUM_BINS     = 128;  // bins read per frame
  localparam int HEIGHT_WIDTH = 9;    // bar height width
  localparam int HEIGHT_MAX   = 400;  // clamp value for height and peak

  // IDLE: wait for a frame, REQ: issue one RAM read, CAP: capture read data,
  // OUT: present the bin to the renderer until accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/fft_bar_scale.sv
// ---------------------------------------------------------------------------
// fft_bar_scale
// Combinational bar math for one bin: scales the RAM magnitude down to a bar
// height, decays the stored peak and keeps the larger of the two.
//
// Ports:
//   mag       in   DATA_WIDTH    unsigned magnitude from the result RAM
//   peak_old  in   HEIGHT_WIDTH  peak-hold value from the previous frame
//   height    out  HEIGHT_WIDTH  min(mag >> SHIFT, HEIGHT_MAX)
//   peak_new  out  HEIGHT_WIDTH  max(height, peak_old - DECAY saturated at 0)
// ---------------------------------------------------------------------------
module fft_bar_scale #(
  parameter int DATA_WIDTH   = 12,
  parameter int HEIGHT_WIDTH = fft_disp_pkg::HEIGHT_WIDTH,
  parameter int HEIGHT_MAX   = fft_disp_pkg::HEIGHT_MAX,
  parameter int SHIFT        = 2,
  parameter int DECAY        = 2
) (
  input  logic [DATA_WIDTH-1:0]   mag,
  input  logic [HEIGHT_WIDTH-1:0] peak_old,
  output logic [HEIGHT_WIDTH-1:0] height,
  output logic [HEIGHT_WIDTH-1:0] peak_new
);

  logic [DATA_WIDTH-1:0]   shifted;
  logic [HEIGHT_WIDTH-1:0] decayed;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    shifted  = mag >> SHIFT;
    height   = '0;
    decayed  = '0;
    peak_new = '0;

    // Clamp on the full-width shifted value; truncating first would wrap
    // large magnitudes into small bars.
    if (32'(shifted) > 32'(HEIGHT_MAX)) begin
      height = HEIGHT_WIDTH'(HEIGHT_MAX);
    end else begin
      height = HEIGHT_WIDTH'(shifted);
    end

    if (32'(peak_old) > 32'(DECAY)) begin
      decayed = peak_old - HEIGHT_WIDTH'(DECAY);
    end

    peak_new = (height > decayed) ? height : decayed;
  end

endmodule

// File: rtl/fft_spectrum_reader.sv
// ---------------------------------------------------------------------------
// fft_spectrum_reader
// Reads one frame of NUM_BINS magnitudes from the FFT result RAM each time
// fft_done is asserted, converts each to a clamped bar height with a decaying
// peak-hold, and streams the bins to the renderer over valid/ready.
//
// Ports:
//   clk                in   pixel clock (single clock domain)
//   rst                in   synchronous reset, active-high
//   fft_done           in   level, frame ready in the result RAM
//   fft_data_out       in   RAM read data, valid the cycle after a request
//   fft_data_out_last  in   FFT side end-of-frame pulse
//   fft_data_out_en    out  RAM read request / clock enable (REQ only)
//   fft_addr_out       out  RAM read address, held outside REQ
//   peak_clr           in   clear all peak-hold values
//   bar_valid/ready    out/in  bin stream handshake
//   bar_idx            out  bin index
//   bar_height         out  scaled, clamped magnitude
//   bar_peak           out  peak-hold value after this frame's update
//   bar_last           out  high with the final bin
//   frame_busy         out  high while outside IDLE
//   sync_err           out  sticky frame-alignment error
// ---------------------------------------------------------------------------
module fft_spectrum_reader #(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_BINS     = fft_disp_pkg::NUM_BINS,
  parameter int HEIGHT_WIDTH = fft_disp_pkg::HEIGHT_WIDTH,
  parameter int HEIGHT_MAX   = fft_disp_pkg::HEIGHT_MAX,
  parameter int SHIFT        = 2,
  parameter int DECAY        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fft_done,
  input  logic [DATA_WIDTH-1:0]   fft_data_out,
  input  logic                    fft_data_out_last,
  output logic                    fft_data_out_en,
  output logic [ADDR_WIDTH-1:0]   fft_addr_out,
  input  logic                    peak_clr,
  output logic                    bar_valid,
  input  logic                    bar_ready,
  output logic [ADDR_WIDTH-1:0]   bar_idx,
  output logic [HEIGHT_WIDTH-1:0] bar_height,
  output logic [HEIGHT_WIDTH-1:0] bar_peak,
  output logic                    bar_last,
  output logic                    frame_busy,
  output logic                    sync_err
);

  import fft_disp_pkg::*;

  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   bin_q, bin_d;
  logic                    done_seen_q, done_seen_d;
  logic                    clr_pend_q, clr_pend_d;
  logic                    sync_err_q, sync_err_d;
  logic                    bar_valid_q, bar_valid_d;
  logic [ADDR_WIDTH-1:0]   bar_idx_q, bar_idx_d;
  logic [HEIGHT_WIDTH-1:0] bar_height_q, bar_height_d;
  logic [HEIGHT_WIDTH-1:0] bar_peak_q, bar_peak_d;
  logic [HEIGHT_WIDTH-1:0] peak_q [NUM_BINS];
  logic [HEIGHT_WIDTH-1:0] peak_d [NUM_BINS];

  logic [BIN_W-1:0]        bin_sel;
  logic [HEIGHT_WIDTH-1:0] h_new, p_new;
  logic                    busy, at_last_bin, in_last_cap, clr_now, start;

  assign bin_sel     = bin_q[BIN_W-1:0];
  assign busy        = (state_q != IDLE);
  assign at_last_bin = (bin_q == LAST_BIN);
  assign in_last_cap = (state_q == CAP) && at_last_bin;

  fft_bar_scale #(
    .DATA_WIDTH  (DATA_WIDTH),
    .HEIGHT_WIDTH(HEIGHT_WIDTH),
    .HEIGHT_MAX  (HEIGHT_MAX),
    .SHIFT       (SHIFT),
    .DECAY       (DECAY)
  ) u_scale (
    .mag     (fft_data_out),
    .peak_old(peak_q[bin_sel]),
    .height  (h_new),
    .peak_new(p_new)
  );

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    done_seen_d  = done_seen_q;
    clr_pend_d   = clr_pend_q;
    sync_err_d   = sync_err_q;
    bar_valid_d  = bar_valid_q;
    bar_idx_d    = bar_idx_q;
    bar_height_d = bar_height_q;
    bar_peak_d   = bar_peak_q;
    peak_d       = peak_q;
    start        = 1'b0;
    // A clear requested in IDLE, or deferred from a busy frame, wins over a
    // frame start so the new frame always sees the cleared peaks.
    clr_now      = !busy && (peak_clr || clr_pend_q);

    unique case (state_q)
      IDLE: begin
        if (clr_now) begin
          for (int i = 0; i < NUM_BINS; i++) peak_d[i] = '0;
          clr_pend_d = 1'b0;
        end else if (fft_done && !done_seen_q) begin
          start   = 1'b1;
          bin_d   = '0;
          state_d = REQ;
        end
      end
      REQ: state_d = CAP;
      CAP: begin
        peak_d[bin_sel] = p_new;
        bar_idx_d       = bin_q;
        bar_height_d    = h_new;
        bar_peak_d      = p_new;
        bar_valid_d     = 1'b1;
        state_d         = OUT;
      end
      OUT: begin
        if (bar_ready) begin
          bar_valid_d = 1'b0;
          if (at_last_bin) begin
            state_d = IDLE;
          end else begin
            bin_d   = bin_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear arriving mid-frame waits for IDLE so this frame keeps old peaks.
    if (busy && peak_clr) clr_pend_d = 1'b1;

    // done_seen re-arms only once fft_done drops, giving one frame per pulse.
    if (!fft_done) begin
      done_seen_d = 1'b0;
    end else if (start) begin
      done_seen_d = 1'b1;
    end

    if (in_last_cap && !fft_data_out_last) sync_err_d = 1'b1;
    if (busy && fft_data_out_last && !in_last_cap) sync_err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      done_seen_q  <= 1'b0;
      clr_pend_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      bar_valid_q  <= 1'b0;
      bar_idx_q    <= '0;
      bar_height_q <= '0;
      bar_peak_q   <= '0;
      // NOTE: the peak array is reset explicitly because a stale peak would
      // be displayed; this keeps it in flops rather than a RAM macro.
      peak_q       <= '{default: '0};
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      done_seen_q  <= done_seen_d;
      clr_pend_q   <= clr_pend_d;
      sync_err_q   <= sync_err_d;
      bar_valid_q  <= bar_valid_d;
      bar_idx_q    <= bar_idx_d;
      bar_height_q <= bar_height_d;
      bar_peak_q   <= bar_peak_d;
      peak_q       <= peak_d;
    end
  end

  // bin_q only moves on entry to REQ, so the address holds outside REQ.
  assign fft_data_out_en = (state_q == REQ);
  assign fft_addr_out    = bin_q;
  assign bar_valid       = bar_valid_q;
  assign bar_idx         = bar_idx_q;
  assign bar_height      = bar_height_q;
  assign bar_peak        = bar_peak_q;
  assign bar_last        = bar_valid_q && (bar_idx_q == LAST_BIN);
  assign frame_busy      = busy;
  assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// ---------------------------------------------------------------------------
// tb_fft_spectrum_reader
// Scoreboard bench: each frame start pushes the expected bins, a negedge
// monitor pops and compares on every bar handshake. A stub RAM answers reads
// one cycle later with a magnitude pattern chosen per frame.
// ---------------------------------------------------------------------------
module tb_fft_spectrum_reader;

  localparam int DW   = 12;
  localparam int AW   = 8;
  localparam int NB   = 128;
  localparam int HW   = 9;
  localparam int HMAX = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          fft_done;
  logic [DW-1:0] fft_data_out = '0;
  logic          fft_data_out_last = 1'b0;
  logic          fft_data_out_en;
  logic [AW-1:0] fft_addr_out;
  logic          peak_clr;
  logic          bar_valid;
  logic          bar_ready;
  logic [AW-1:0] bar_idx;
  logic [HW-1:0] bar_height;
  logic [HW-1:0] bar_peak;
  logic          bar_last;
  logic          frame_busy;
  logic          sync_err;

  always #5 clk = ~clk;

  fft_spectrum_reader dut (
    .clk              (clk),
    .rst              (rst),
    .fft_done         (fft_done),
    .fft_data_out     (fft_data_out),
    .fft_data_out_last(fft_data_out_last),
    .fft_data_out_en  (fft_data_out_en),
    .fft_addr_out     (fft_addr_out),
    .peak_clr         (peak_clr),
    .bar_valid        (bar_valid),
    .bar_ready        (bar_ready),
    .bar_idx          (bar_idx),
    .bar_height       (bar_height),
    .bar_peak         (bar_peak),
    .bar_last         (bar_last),
    .frame_busy       (frame_busy),
    .sync_err         (sync_err)
  );

  typedef struct {
    int idx;
    int height;
    int peak;
    int last;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   mag_mode = 0;       // 0: 4*addr, 1: 4095, 2: 0
  int   last_target = NB - 1;
  int   req_cnt = 0;
  int   busy_cycles = 0;
  int   model_peak [NB];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int ram_mag(input int addr);
    case (mag_mode)
      0:       return 4 * addr;
      1:       return 4095;
      default: return 0;
    endcase
  endfunction

  // Stub result RAM: registered read, end-of-frame flag beside the data of
  // the request at last_target.
  always @(posedge clk) begin
    if (fft_data_out_en) fft_data_out <= DW'(ram_mag(int'(fft_addr_out)));
    fft_data_out_last <= fft_data_out_en && (int'(fft_addr_out) == last_target);
  end

  // Monitor: counts requests and busy cycles, compares each accepted bin.
  always @(negedge clk) begin
    if (!rst) begin
      if (fft_data_out_en) req_cnt++;
      if (frame_busy) busy_cycles++;
      if (bar_valid && bar_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_bin", 32'(bar_idx), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("bar_idx", 32'(bar_idx), 32'(e.idx));
          check("bar_height", 32'(bar_height), 32'(e.height));
          check("bar_peak", 32'(bar_peak), 32'(e.peak));
          check("bar_last", 32'(bar_last), 32'(e.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) model_peak[i] = 0;
  endtask

  // Push the expected bins of the next frame and advance the peak model.
  task automatic push_frame();
    for (int i = 0; i < NB; i++) begin
      int mag, h, dec, p;
      mag = ram_mag(i);
      h   = ((mag >> 2) > HMAX) ? HMAX : (mag >> 2);
      dec = (model_peak[i] > 2) ? model_peak[i] - 2 : 0;
      p   = (h > dec) ? h : dec;
      model_peak[i] = p;
      sb_q.push_back('{idx: i, height: h, peak: p, last: (i == NB - 1)});
    end
  endtask

  task automatic start_frame(input int mode);
    mag_mode = mode;
    push_frame();
    fft_done = 1'b1;
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(bar_valid && int'(bar_idx) == idx) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("wait_idx_timeout", 32'(n), 32'(0));
  endtask

  task automatic finish_frame(input string tag);
    int n = 0;
    while (!frame_busy && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) check({tag, "_start_timeout"}, 32'(n), 32'(0));
    n = 0;
    while (frame_busy && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) check({tag, "_end_timeout"}, 32'(n), 32'(0));
    fft_done = 1'b0;
    tick();
    tick();
    check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    rst       = 1'b1;
    fft_done  = 1'b0;
    peak_clr  = 1'b0;
    bar_ready = 1'b1;
    clear_model();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_bar_valid", 32'(bar_valid), 32'(0));
    check("rst_en", 32'(fft_data_out_en), 32'(0));
    check("rst_addr", 32'(fft_addr_out), 32'(0));
    check("rst_busy", 32'(frame_busy), 32'(0));
    check("rst_sync_err", 32'(sync_err), 32'(0));
    check("rst_height", 32'(bar_height), 32'(0));
    check("rst_last", 32'(bar_last), 32'(0));

    // F1: ramp, heights 0..127, peaks equal heights
    req_cnt = 0;
    busy_cycles = 0;
    start_frame(0);
    finish_frame("f1");
    check("f1_requests", 32'(req_cnt), 32'(NB));
    check("f1_busy_cycles", 32'(busy_cycles), 32'(3 * NB));
    check("f1_sync_err", 32'(sync_err), 32'(0));
    check("f1_addr_hold", 32'(fft_addr_out), 32'(NB - 1));
    check("f1_en_idle", 32'(fft_data_out_en), 32'(0));

    // F2: zeros, peaks decay by 2 and saturate at 0 for bins 0..2
    start_frame(2);
    finish_frame("f2");

    // F3: full scale clamps to 400
    start_frame(1);
    finish_frame("f3");

    // F4: zeros with peak_clr mid-frame, this frame still shows 398
    start_frame(2);
    wait_idx(60);
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    finish_frame("f4");
    clear_model();

    // F5: ramp after deferred clear (peak = height), backpressure at bin 5
    start_frame(0);
    wait_idx(5);
    bar_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", 32'(bar_valid), 32'(1));
      check("bp_idx", 32'(bar_idx), 32'(5));
      check("bp_height", 32'(bar_height), 32'(5));
      check("bp_no_req", 32'(fft_data_out_en), 32'(0));
    end
    bar_ready = 1'b1;
    finish_frame("f5");

    // F6 full scale, then F7 ramp started together with peak_clr
    start_frame(1);
    finish_frame("f6");
    clear_model();
    peak_clr = 1'b1;
    start_frame(0);
    tick();
    peak_clr = 1'b0;
    check("clr_first_no_busy", 32'(frame_busy), 32'(0));
    finish_frame("f7");

    // F8: end-of-frame flag one bin early, F9 normal: sync_err sticky
    last_target = NB - 2;
    start_frame(0);
    finish_frame("f8");
    check("f8_sync_err", 32'(sync_err), 32'(1));
    last_target = NB - 1;
    start_frame(0);
    finish_frame("f9");
    check("f9_sync_err_sticky", 32'(sync_err), 32'(1));

    // F10: reset at bin 40 with fft_done held high, restart from addr 0
    start_frame(0);
    wait_idx(40);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bar_valid), 32'(0));
    check("mid_rst_idx", 32'(bar_idx), 32'(0));
    check("mid_rst_height", 32'(bar_height), 32'(0));
    check("mid_rst_peak", 32'(bar_peak), 32'(0));
    check("mid_rst_en", 32'(fft_data_out_en), 32'(0));
    check("mid_rst_addr", 32'(fft_addr_out), 32'(0));
    check("mid_rst_busy", 32'(frame_busy), 32'(0));
    check("mid_rst_sync_err", 32'(sync_err), 32'(0));
    rst = 1'b0;
    sb_q.delete();
    clear_model();
    push_frame();
    begin
      int n = 0;
      while (!fft_data_out_en && n < 10) begin
        tick();
        n++;
      end
      check("restart_req_seen", 32'(fft_data_out_en), 32'(1));
      check("restart_addr", 32'(fft_addr_out), 32'(0));
    end
    finish_frame("f10");
    check("f10_sync_err", 32'(sync_err), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
